// File: rtl/mole_spawn_scheduler_pkg.sv
// Shared definitions for the mole spawn scheduler and its helpers.
//   - NUM_HOLES / index widths for the 16-hole board
//   - level encodings (LVL_NONE, LVL_1..LVL_3)
//   - scheduler FSM state encoding
//   - default period / occupancy-cap constants per level
//   - hole_onehot(): index to one-hot hole vector
package mole_spawn_scheduler_pkg;

    localparam int NUM_HOLES  = 16;
    localparam int HOLE_IDX_W = 4;
    localparam int CNT_W      = 5;   // wide enough for a popcount of 0..16

    localparam int DEF_PERIOD_L1 = 8;
    localparam int DEF_PERIOD_L2 = 6;
    localparam int DEF_PERIOD_L3 = 4;
    localparam int DEF_MAX_L1    = 2;
    localparam int DEF_MAX_L2    = 3;
    localparam int DEF_MAX_L3    = 4;

    typedef enum logic [1:0] {
        LVL_NONE = 2'd0,
        LVL_1    = 2'd1,
        LVL_2    = 2'd2,
        LVL_3    = 2'd3
    } level_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PICK  = 2'd2,
        ISSUE = 2'd3
    } state_e;

    function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [HOLE_IDX_W-1:0] idx);
        logic [NUM_HOLES-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mole_spawn_scheduler_popcount16.sv
// popcount16: combinational count of set bits in a 16-bit vector.
//   bits  in  16  vector to count
//   count out 5   number of ones (0..16)
// Built as a ripple accumulator; shared with the score logic.
module popcount16
    import mole_spawn_scheduler_pkg::*;
(
    input  logic [NUM_HOLES-1:0] bits,
    output logic [CNT_W-1:0]     count
);

    for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_acc
        logic [CNT_W-1:0] sum;
        if (gi == 0) begin : g_first
            assign sum = {{(CNT_W-1){1'b0}}, bits[0]};
        end else begin : g_rest
            assign sum = g_acc[gi-1].sum + {{(CNT_W-1){1'b0}}, bits[gi]};
        end
    end

    assign count = g_acc[NUM_HOLES-1].sum;

endmodule

// File: rtl/mole_spawn_scheduler.sv
// mole_spawn_scheduler: on a level-dependent tick schedule, picks one free
// hole starting at a random index and issues a single-cycle spawn request,
// while keeping the number of occupied holes under a per-level cap.
//   clk          in   master clock
//   rst_n        in   asynchronous active-low reset
//   tick         in   one-clk animation-rate enable
//   run          in   game running and not paused
//   level        in   selected level, sampled on the rising edge of run
//   rand_word    in   LFSR word; [3:0] is the scan start index
//   hole_busy    in   per-hole "mole showing" status
//   spawn        out  one-hot, one-clk spawn request
//   active_cnt   out  registered popcount of occupied holes
//   spawn_total  out  spawns issued this run, saturating at 1023
module mole_spawn_scheduler
    import mole_spawn_scheduler_pkg::*;
#(
    parameter int PERIOD_L1 = DEF_PERIOD_L1,
    parameter int PERIOD_L2 = DEF_PERIOD_L2,
    parameter int PERIOD_L3 = DEF_PERIOD_L3,
    parameter int MAX_L1    = DEF_MAX_L1,
    parameter int MAX_L2    = DEF_MAX_L2,
    parameter int MAX_L3    = DEF_MAX_L3
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 run,
    input  logic [1:0]           level,
    input  logic [15:0]          rand_word,
    input  logic [NUM_HOLES-1:0] hole_busy,
    output logic [NUM_HOLES-1:0] spawn,
    output logic [CNT_W-1:0]     active_cnt,
    output logic [9:0]           spawn_total
);

    state_e                 state_reg, state_next;
    level_e                 level_q_reg;
    logic                   run_q_reg;
    logic [7:0]             tick_cnt_reg;
    logic [HOLE_IDX_W-1:0]  idx_reg;
    logic [HOLE_IDX_W-1:0]  chk_reg;
    logic [NUM_HOLES-1:0]   pending_reg;
    logic [NUM_HOLES-1:0]   spawn_reg;
    logic [CNT_W-1:0]       active_cnt_reg;
    logic [9:0]             spawn_total_reg;

    logic [NUM_HOLES-1:0]   occupied;
    logic [NUM_HOLES-1:0]   issue_mask;
    logic [CNT_W-1:0]       occ_cnt;
    logic [7:0]             period_sel;
    logic [CNT_W-1:0]       max_sel;
    logic                   run_rise;
    logic                   period_end;
    logic                   load_idx;
    logic                   step_idx;
    logic                   do_issue;
    logic                   unused_rand;

    assign unused_rand = ^rand_word[15:HOLE_IDX_W];

    // A hole counts as occupied from the cycle it is requested until the
    // moles block reports it busy, so it cannot be picked twice.
    assign occupied   = hole_busy | pending_reg;
    assign run_rise   = run & ~run_q_reg;
    assign period_end = tick && (tick_cnt_reg == period_sel - 8'd1);
    assign issue_mask = do_issue ? hole_onehot(idx_reg) : '0;

    popcount16 u_popcount (
        .bits  (occupied),
        .count (occ_cnt)
    );

    // LVL_NONE keeps max at 0, so the cap comparison never lets an attempt through.
    always_comb begin
        period_sel = 8'(PERIOD_L1);
        max_sel    = '0;
        case (level_q_reg)
            LVL_1: begin period_sel = 8'(PERIOD_L1); max_sel = CNT_W'(MAX_L1); end
            LVL_2: begin period_sel = 8'(PERIOD_L2); max_sel = CNT_W'(MAX_L2); end
            LVL_3: begin period_sel = 8'(PERIOD_L3); max_sel = CNT_W'(MAX_L3); end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load_idx   = 1'b0;
        step_idx   = 1'b0;
        do_issue   = 1'b0;
        if (!run) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:  state_next = COUNT;
                COUNT: begin
                    if (period_end && (active_cnt_reg < max_sel)) begin
                        state_next = PICK;
                        load_idx   = 1'b1;
                    end
                end
                PICK: begin
                    if (!occupied[idx_reg]) begin
                        state_next = ISSUE;
                    end else if (chk_reg == 4'd15) begin
                        state_next = COUNT;     // full lap, nothing free
                    end else begin
                        step_idx = 1'b1;
                    end
                end
                ISSUE: begin
                    do_issue   = 1'b1;
                    state_next = COUNT;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q_reg       <= 1'b0;
            level_q_reg     <= LVL_NONE;
            tick_cnt_reg    <= '0;
            idx_reg         <= '0;
            chk_reg         <= '0;
            pending_reg     <= '0;
            spawn_reg       <= '0;
            active_cnt_reg  <= '0;
            spawn_total_reg <= '0;
        end else begin
            run_q_reg <= run;
            spawn_reg <= issue_mask;

            if (run_rise) begin
                level_q_reg     <= level_e'(level);
                tick_cnt_reg    <= '0;
                spawn_total_reg <= '0;
            end else if (state_reg != IDLE && tick) begin
                // Ticks keep counting while a pick/issue is in flight.
                tick_cnt_reg <= period_end ? 8'd0 : tick_cnt_reg + 8'd1;
            end

            if (load_idx) begin
                idx_reg <= rand_word[HOLE_IDX_W-1:0];
                chk_reg <= '0;
            end else if (step_idx) begin
                idx_reg <= idx_reg + 4'd1;
                chk_reg <= chk_reg + 4'd1;
            end

            if (!run || run_rise) pending_reg <= '0;
            else                  pending_reg <= (pending_reg & ~hole_busy) | issue_mask;

            // Counters freeze while stopped so the final figures stay on display.
            if (run) active_cnt_reg <= occ_cnt;

            if (do_issue && spawn_total_reg != 10'h3FF)
                spawn_total_reg <= spawn_total_reg + 10'd1;
        end
    end

    assign spawn       = spawn_reg;
    assign active_cnt  = active_cnt_reg;
    assign spawn_total = spawn_total_reg;

endmodule

// File: tb/tb_mole_spawn_scheduler.sv
// Scoreboard bench for mole_spawn_scheduler: directed scenarios push the
// expected spawn (hole, running total, cycle) into a queue; a negedge
// monitor pops and compares every spawn pulse the DUT produces.
module tb_mole_spawn_scheduler;
    import mole_spawn_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, tick, run;
    logic [1:0]  level;
    logic [15:0] rand_word, hole_busy, spawn;
    logic [4:0]  active_cnt;
    logic [9:0]  spawn_total;

    int     n_tests  = 0;
    int     n_failed = 0;
    longint cyc      = 0;

    typedef struct {
        logic [15:0] spawn;
        int          total;
        longint      cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mole_spawn_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .run         (run),
        .level       (level),
        .rand_word   (rand_word),
        .hole_busy   (hole_busy),
        .spawn       (spawn),
        .active_cnt  (active_cnt),
        .spawn_total (spawn_total)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every spawn pulse is one transaction.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && spawn !== 16'h0000) begin
            $display("[TB] spawn=%h total=%0d cycle=%0d", spawn, spawn_total, cyc);
            check("spawn_onehot", longint'($onehot(spawn)), 1);
            check("spawn_on_busy", longint'(spawn & hole_busy), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_spawn", longint'(spawn), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("spawn_hole", longint'(spawn), longint'(mon_e.spawn));
                check("spawn_total", longint'(spawn_total), longint'(mon_e.total));
                check("spawn_latency", cyc, mon_e.cyc);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input logic [1:0] lvl, input logic [15:0] rnd, input logic [15:0] busy);
        run = 1'b0;
        step();
        level     = lvl;
        rand_word = rnd;
        hole_busy = busy;
        run       = 1'b1;
        step();
    endtask

    task automatic do_ticks(input int n, input int gap);
        repeat (n) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step(gap - 1);
        end
    endtask

    // Final tick of a period; the spawn is expected lat clocks after this edge.
    task automatic fire(input logic [15:0] exp_spawn, input int exp_total, input int lat);
        exp_t e;
        tick = 1'b1;
        step();
        e.spawn = exp_spawn;
        e.total = exp_total;
        e.cyc   = cyc + lat;
        exp_q.push_back(e);
        tick = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; run = 1'b0; level = 2'd0;
        rand_word = 16'h0; hole_busy = 16'h0;
        step(3);
        check("rst_spawn", longint'(spawn), 0);
        check("rst_active_cnt", longint'(active_cnt), 0);
        check("rst_spawn_total", longint'(spawn_total), 0);
        check("rst_state", longint'(dut.state_reg), longint'(IDLE));
        rst_n = 1'b1;
        step(2);

        // Level 1, start index 5, empty board; then pending blocks hole 5.
        start_run(2'd1, 16'h0005, 16'h0000);
        do_ticks(7, 4);
        fire(16'h0020, 1, 2);
        step(3);
        repeat (20) begin
            check("hold_active_cnt", longint'(active_cnt), 1);
            step();
        end
        do_ticks(7, 2);
        fire(16'h0040, 2, 3);
        step(4);
        check("two_pending_active", longint'(active_cnt), 2);
        run = 1'b0;
        step();
        check("stop_state", longint'(dut.state_reg), longint'(IDLE));
        check("stop_pending", longint'(dut.pending_reg), 0);
        check("stop_total_held", longint'(spawn_total), 2);
        check("stop_active_held", longint'(active_cnt), 2);
        step(3);

        // Level 3, board full: every attempt skipped.
        start_run(2'd3, 16'h1234, 16'hFFFF);
        do_ticks(100, 2);
        check("full_total", longint'(spawn_total), 0);
        check("full_active", longint'(active_cnt), 16);

        // Level 2 at cap, then free hole 0.
        start_run(2'd2, 16'h0000, 16'h0007);
        do_ticks(12, 2);
        check("cap_total", longint'(spawn_total), 0);
        check("cap_active", longint'(active_cnt), 3);
        hole_busy = 16'h0006;
        do_ticks(5, 2);
        fire(16'h0001, 1, 2);
        step(3);
        check("cap_refill_active", longint'(active_cnt), 3);
        step(4);

        // Start index 15 on an empty board.
        start_run(2'd1, 16'h000F, 16'h0000);
        do_ticks(7, 2);
        fire(16'h8000, 1, 2);
        step(6);

        // Start index 15, holes 15,0,1 busy: scan wraps to hole 2.
        start_run(2'd3, 16'h000F, 16'h8003);
        do_ticks(3, 2);
        fire(16'h0004, 1, 5);
        step(8);

        // Board fills up after PICK starts: 16 failed checks, back to COUNT.
        start_run(2'd3, 16'h0000, 16'h0000);
        do_ticks(3, 2);
        tick = 1'b1;
        step();
        tick = 1'b0;
        hole_busy = 16'hFFFF;
        check("miss_state_pick", longint'(dut.state_reg), longint'(PICK));
        step(15);
        check("miss_still_pick", longint'(dut.state_reg), longint'(PICK));
        step();
        check("miss_state_count", longint'(dut.state_reg), longint'(COUNT));
        check("miss_total", longint'(spawn_total), 0);
        step(4);

        // Asynchronous reset in the middle of PICK.
        start_run(2'd3, 16'h0004, 16'h0001);
        do_ticks(3, 2);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("rstpick_state", longint'(dut.state_reg), longint'(PICK));
        check("rstpick_active", longint'(active_cnt), 1);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("rstpick_async_state", longint'(dut.state_reg), longint'(IDLE));
        check("rstpick_async_active", longint'(active_cnt), 0);
        check("rstpick_async_spawn", longint'(spawn), 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("rstpick_after_state", longint'(dut.state_reg), longint'(IDLE));
        check("rstpick_after_spawn", longint'(spawn), 0);
        check("rstpick_after_total", longint'(spawn_total), 0);
        step(2);

        check("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
